// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared types and constants for the register-file dump scanner
// Optional checksum word is enabled by REGFILE_DUMP_CHECKSUM_EN, which adds the CKSUM state.
package regfile_dump_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
`ifdef REGFILE_DUMP_CHECKSUM_EN
    , ST_CKSUM
`endif
  } state_e;

endpackage

// File: rtl/dump_settle_timer.sv
// rtl/dump_settle_timer.sv - loadable down-counter with zero flag
// Holds at zero; a load takes priority over counting.
module dump_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_dump_scanner.sv
// rtl/regfile_dump_scanner.sv - sweeps the CPU register file and streams (address, data) pairs
// REGFILE_DUMP_CHECKSUM_EN appends an XOR-of-all-registers word carrying out_last.
module regfile_dump_scanner
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk_100Mhz,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              tmr_load, tmr_zero, at_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;
`endif

  assign at_last  = (rf_addr_q == ADDR_MAX);
  // Reload on dump start and on every non-final handshake that moves to the next address.
  assign tmr_load = ((state_q == ST_IDLE) && start) ||
                    ((state_q == ST_SEND) && out_ready && !out_last_q && !at_last);

  dump_settle_timer #(.W(4)) u_timer (
    .clk_i      (clk_100Mhz),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .en_i       (state_q == ST_SETTLE),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rf_addr_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETTLE;
      ST_SETTLE:  if (tmr_zero) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (out_ready) begin
          if (out_last_q)   state_d = ST_DONE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          else if (at_last) state_d = ST_CKSUM;
`endif
          else              state_d = ST_SETTLE;
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_CKSUM:   state_d = ST_SEND;
`endif
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_addr_d   = rf_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rf_addr_d = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          cksum_d   = '0;
`endif
        end
      end
      ST_CAPTURE: begin
        out_data_d  = rf_data;
        out_addr_d  = rf_addr_q;
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        cksum_d     = cksum_q ^ rf_data;
`else
        out_last_d  = at_last;
`endif
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q)    out_last_d = 1'b0;
          else if (!at_last) rf_addr_d  = rf_addr_q + 1'b1;
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_CKSUM: begin
        out_data_d  = cksum_q;
        out_addr_d  = '0;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign rf_addr   = rf_addr_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_scanner.sv
// tb/tb_regfile_dump_scanner.sv - randomized self-checking bench against a word-list reference model
module tb_regfile_dump_scanner;
  import regfile_dump_pkg::*;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CK   = 1'b1;
`else
  localparam bit CK   = 1'b0;
`endif
  localparam int NEXP = NREG + (CK ? 1 : 0);

  logic          clk_100Mhz = 1'b0;
  logic          rst = 1'b1, start = 1'b0, out_ready = 1'b0, corrupt = 1'b0;
  logic [AW-1:0] rf_addr, out_addr;
  logic [DW-1:0] rf_data, out_data;
  logic          out_valid, out_last, busy, done;
  logic [DW-1:0] regs [NREG];
  int            n_checks = 0, n_fail = 0;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    bit            last;
  } word_t;
  word_t exp_q[$];

  always #5 clk_100Mhz = ~clk_100Mhz;
  assign rf_data = corrupt ? 32'hDEADBEEF : regs[rf_addr];

  regfile_dump_scanner #(.ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(2)) dut (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .start      (start),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every register in address order, then the XOR word when enabled.
  task automatic build_expect();
    logic [DW-1:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back('{i, regs[i], (i == NREG - 1) && !CK});
      x ^= regs[i];
    end
    if (CK) exp_q.push_back('{0, x, 1'b1});
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, ".rf_addr"},   64'(rf_addr),   64'(0));
    expect_eq({tag, ".out_valid"}, 64'(out_valid), 64'(0));
    expect_eq({tag, ".out_addr"},  64'(out_addr),  64'(0));
    expect_eq({tag, ".out_data"},  64'(out_data),  64'(0));
    expect_eq({tag, ".out_last"},  64'(out_last),  64'(0));
    expect_eq({tag, ".busy"},      64'(busy),      64'(0));
    expect_eq({tag, ".done"},      64'(done),      64'(0));
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < NREG; i++) regs[i] = $urandom();
  endtask

  task automatic run_dump(input int stall_at, input int restart_at, input int rst_at,
                          input bit rnd_ready, input bit start_at_done);
    int            cyc, last_rise, stall_cnt, done_cnt, stable_run, words;
    bit            prev_valid, restarted, finished;
    logic [AW-1:0] prev_addr;
    word_t         w;
    cyc = 0; last_rise = -1; stall_cnt = 0; done_cnt = 0; stable_run = 0; words = 0;
    prev_valid = 1'b0; restarted = 1'b0; finished = 1'b0;
    build_expect();
    @(negedge clk_100Mhz);
    start = 1'b1;
    @(negedge clk_100Mhz);
    start = 1'b0;
    expect_eq("busy_after_start", 64'(busy), 64'(1));
    prev_addr = rf_addr;
    while (!finished && cyc < 2000) begin
      @(negedge clk_100Mhz);
      cyc++;
      start = 1'b0;
      stable_run = (rf_addr == prev_addr) ? stable_run + 1 : 0;
      prev_addr  = rf_addr;
      if (done_cnt > 0) begin
        expect_eq("busy_after_done", 64'(busy), 64'(0));
        expect_eq("done_width", 64'(done), 64'(0));
        expect_eq("rf_addr_hold_last", 64'(rf_addr), 64'(LAST_ADDR));
        finished = 1'b1;
      end else if (done) begin
        done_cnt++;
        start = start_at_done;
      end
      if (out_valid && !prev_valid) begin
        if (!rnd_ready && stall_at < 0 && out_addr != 0)
          expect_eq("valid_spacing", 64'(cyc - last_rise), 64'(4));
        expect_eq("rf_addr_settled", 64'(stable_run >= 3), 64'(1));
        last_rise = cyc;
      end
      prev_valid = out_valid;
      if (out_valid && rst_at >= 0 && int'(out_addr) == rst_at) begin
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk_100Mhz);
        rst       = 1'b0;
        out_ready = 1'b0;
        check_reset_outputs("rst_abort");
        repeat (6) @(negedge clk_100Mhz);
        expect_eq("abort_no_valid", 64'(out_valid), 64'(0));
        expect_eq("abort_no_busy", 64'(busy), 64'(0));
        return;
      end
      if (out_valid && restart_at >= 0 && int'(out_addr) == restart_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (out_valid && stall_at >= 0 && int'(out_addr) == stall_at && stall_cnt < 10) begin
        out_ready = 1'b0;
        corrupt   = 1'b1;
        stall_cnt++;
        if (stall_cnt == 10) begin
          expect_eq("stall_valid", 64'(out_valid), 64'(1));
          expect_eq("stall_addr", 64'(out_addr), 64'(stall_at));
          expect_eq("stall_data", 64'(out_data), 64'(regs[stall_at]));
          expect_eq("stall_rf_addr", 64'(rf_addr), 64'(stall_at));
        end
      end else begin
        corrupt   = 1'b0;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          expect_eq("word_overflow", 64'(words + 1), 64'(NEXP));
        end else begin
          w = exp_q.pop_front();
          expect_eq($sformatf("w%0d.addr", words), 64'(out_addr), 64'(w.addr));
          expect_eq($sformatf("w%0d.data", words), 64'(out_data), 64'(w.data));
          expect_eq($sformatf("w%0d.last", words), 64'(out_last), 64'(w.last));
        end
        words++;
      end
    end
    out_ready = 1'b0;
    corrupt   = 1'b0;
    start     = 1'b0;
    expect_eq("dump_finished", 64'(finished), 64'(1));
    expect_eq("word_count", 64'(words), 64'(NEXP));
    expect_eq("done_pulses", 64'(done_cnt), 64'(1));
    @(negedge clk_100Mhz);
    expect_eq("idle_after_dump", 64'(busy), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000_0000 + i;
    rst = 1'b1;
    repeat (2) @(negedge clk_100Mhz);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_dump(-1, -1, -1, 1'b0, 1'b0);
    randomize_regs();
    run_dump(7, -1, -1, 1'b0, 1'b0);
    randomize_regs();
    run_dump(-1, 12, -1, 1'b1, 1'b1);
    randomize_regs();
    run_dump(-1, -1, 20, 1'b0, 1'b0);
    randomize_regs();
    run_dump(-1, -1, -1, 1'b1, 1'b0);
    if (CK) begin
      for (int i = 0; i < NREG; i++) regs[i] = i;
      run_dump(-1, -1, -1, 1'b0, 1'b0);
      for (int i = 0; i < NREG; i++) regs[i] = 32'd1 << i;
      run_dump(-1, -1, -1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
